frame_seq_ctrl: RTL and testbench

Frame sequencer that sits in front of the raw2gray datapath. It owns the active frame geometry and accepts 36-bit control packets, applying them only at frame boundaries. It gates the Bayer pixel stream into the datapath per frame and tracks pixel position, emitting sof/eol/eof qualifiers. It issues the halved-resolution control packet downstream whenever the geometry takes effect.

---
 rtl/frame_seq_pkg.sv | 20 ++
 rtl/frame_seq_ctrl_if.sv | 35 +++
 rtl/frame_seq_ctrl_pos_cnt.sv | 49 ++++
 rtl/frame_seq_ctrl.sv | 113 +++++++++++
 tb/tb_frame_seq_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_seq_pkg.sv
// Shared types and control-packet layout for the raw2gray frame sequencer.
// The helper builds the halved-geometry packet sent to the downstream stage.
package frame_seq_pkg;

  typedef enum logic [1:0] {StCfg, StActive, StGap} state_e;

  localparam int unsigned DimW  = 16;
  localparam int unsigned CtrlW = 36;

  localparam int unsigned WMsb = 35;
  localparam int unsigned WLsb = 20;
  localparam int unsigned HMsb = 19;
  localparam int unsigned HLsb = 4;

  function automatic logic [CtrlW-1:0] half_dims(input logic [DimW-1:0] w,
                                                 input logic [DimW-1:0] h);
    return {w >> 1, h >> 1, 4'h0};
  endfunction

endpackage

// File: rtl/frame_seq_ctrl_if.sv
// Handshake bundle of the frame sequencer: control in/out, pixel gate and qualifiers.
// master is the surrounding pipeline, slave is the sequencer itself.
interface frame_seq_ctrl_if;
  import frame_seq_pkg::*;

  logic [CtrlW-1:0] ctrl_in_data;
  logic             ctrl_in_valid;
  logic             ctrl_in_ready;
  logic             pix_valid;
  logic             pix_ready;
  logic             dp_ready;
  logic             dp_en;
  logic [DimW-1:0]  x;
  logic [DimW-1:0]  y;
  logic             sof;
  logic             eol;
  logic             eof;
  logic [CtrlW-1:0] ctrl_out_data;
  logic             ctrl_out_valid;
  logic             ctrl_out_ready;
  logic             cfg_err;

  modport master (
    output ctrl_in_data, ctrl_in_valid, pix_valid, dp_ready, ctrl_out_ready,
    input  ctrl_in_ready, pix_ready, dp_en, x, y, sof, eol, eof,
    input  ctrl_out_data, ctrl_out_valid, cfg_err
  );

  modport slave (
    input  ctrl_in_data, ctrl_in_valid, pix_valid, dp_ready, ctrl_out_ready,
    output ctrl_in_ready, pix_ready, dp_en, x, y, sof, eol, eof,
    output ctrl_out_data, ctrl_out_valid, cfg_err
  );

endinterface

// File: rtl/frame_seq_ctrl_pos_cnt.sv
// Raster position counter: x runs across the row, y down the frame, both wrap at the
// frame end. last_col/last_pix describe the position about to be consumed.
module frame_pos_cnt
  import frame_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [DimW-1:0] width,
  input  logic [DimW-1:0] height,
  output logic [DimW-1:0] x,
  output logic [DimW-1:0] y,
  output logic            last_col,
  output logic            last_pix
);

  logic [DimW-1:0] x_q, x_d;
  logic [DimW-1:0] y_q, y_d;

  assign last_col = (x_q == width - 16'd1);
  assign last_pix = last_col & (y_q == height - 16'd1);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (en) begin
      if (last_col) begin
        x_d = '0;
        y_d = last_pix ? '0 : y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/frame_seq_ctrl.sv
// Frame sequencer ahead of raw2gray: gates pixels per frame, tracks position and
// swaps in new geometry only in the inter-frame gap, announcing it downstream.
module frame_seq_ctrl
  import frame_seq_pkg::*;
#(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned W_DEF    = 1920,
  parameter int unsigned H_DEF    = 1080
) (
  input logic              clk,
  input logic              rst,
  frame_seq_ctrl_if.slave  bus
);

  localparam int unsigned UnusedBitwidth = BITWIDTH;
  localparam logic [DimW-1:0] WDef = DimW'(W_DEF);
  localparam logic [DimW-1:0] HDef = DimW'(H_DEF);

  state_e          state_q;
  logic            ctrl_out_valid_q;
  logic            cfg_err_q;
  logic            pend_vld_q;
  logic [DimW-1:0] cur_w_q, cur_h_q;
  logic [DimW-1:0] pend_w_q, pend_h_q;

  logic            pix_ready, dp_en, last_col, last_pix;
  logic [DimW-1:0] pos_x, pos_y;
  logic [DimW-1:0] in_w, in_h;
  logic            in_acc, in_bad, in_same;
  logic            unused_ctrl_bits;

  assign in_w    = bus.ctrl_in_data[WMsb:WLsb];
  assign in_h    = bus.ctrl_in_data[HMsb:HLsb];
  assign in_acc  = bus.ctrl_in_valid & ~pend_vld_q;
  assign in_bad  = (in_w == '0) | (in_h == '0) | in_w[0] | in_h[0];
  assign in_same = (in_w == cur_w_q) & (in_h == cur_h_q);
  assign unused_ctrl_bits = ^bus.ctrl_in_data[HLsb-1:0];

  assign pix_ready = (state_q == StActive) & bus.dp_ready;
  assign dp_en     = bus.pix_valid & pix_ready;

  frame_pos_cnt u_pos (
    .clk      (clk),
    .rst      (rst),
    .en       (dp_en),
    .width    (cur_w_q),
    .height   (cur_h_q),
    .x        (pos_x),
    .y        (pos_y),
    .last_col (last_col),
    .last_pix (last_pix)
  );

  // Acceptance (needs an empty slot) and apply (needs a full one) never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StCfg;
      ctrl_out_valid_q <= 1'b1;
      cfg_err_q        <= 1'b0;
      pend_vld_q       <= 1'b0;
      cur_w_q          <= WDef;
      cur_h_q          <= HDef;
      pend_w_q         <= '0;
      pend_h_q         <= '0;
    end else begin
      cfg_err_q <= in_acc & in_bad;
      if (in_acc & ~in_bad & ~in_same) begin
        pend_vld_q <= 1'b1;
        pend_w_q   <= in_w;
        pend_h_q   <= in_h;
      end
      unique case (state_q)
        StCfg: begin
          if (bus.ctrl_out_ready) begin
            state_q          <= StActive;
            ctrl_out_valid_q <= 1'b0;
          end
        end
        StActive: begin
          if (dp_en & last_pix) state_q <= StGap;
        end
        StGap: begin
          if (pend_vld_q) begin
            cur_w_q          <= pend_w_q;
            cur_h_q          <= pend_h_q;
            pend_vld_q       <= 1'b0;
            state_q          <= StCfg;
            ctrl_out_valid_q <= 1'b1;
          end else begin
            state_q <= StActive;
          end
        end
        default: begin
          state_q          <= StCfg;
          ctrl_out_valid_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ctrl_in_ready  = ~pend_vld_q;
  assign bus.pix_ready      = pix_ready;
  assign bus.dp_en          = dp_en;
  assign bus.x              = pos_x;
  assign bus.y              = pos_y;
  assign bus.sof            = dp_en & (pos_x == '0) & (pos_y == '0);
  assign bus.eol            = dp_en & last_col;
  assign bus.eof            = dp_en & last_pix;
  assign bus.ctrl_out_data  = half_dims(cur_w_q, cur_h_q);
  assign bus.ctrl_out_valid = ctrl_out_valid_q;
  assign bus.cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Bench for frame_seq_ctrl: vector table, directed corner sequences and random traffic
// checked every cycle against a beat-index model of the frame sequencer.
module tb_frame_seq_ctrl;
  import frame_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_seq_ctrl_if bus ();
  frame_seq_ctrl_if big ();

  frame_seq_ctrl #(.BITWIDTH(8), .W_DEF(4), .H_DEF(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  frame_seq_ctrl dut_big (
    .clk (clk),
    .rst (rst),
    .bus (big)
  );

  int total = 0;
  int bad   = 0;

  localparam int MCfg = 0;
  localparam int MAct = 1;
  localparam int MGap = 2;

  // Model: geometry, one pending slot, mode, and linear beat index within the frame.
  int m_w, m_h, m_pw, m_ph, m_mode, m_k, dut_beats;
  bit m_pend, m_err;

  int wsel[6] = '{2, 4, 6, 8, 3, 0};
  int hsel[4] = '{2, 4, 1, 0};

  typedef struct {
    bit pv, dr, cor;
    bit pr, en;
    int x, y;
    bit sof, eol, eof, cov;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_w = 4; m_h = 2; m_pw = 0; m_ph = 0;
    m_pend = 0; m_mode = MCfg; m_k = 0; m_err = 0; dut_beats = 0;
  endtask

  task automatic drive(input bit pv, input bit dr, input bit cor, input bit civ,
                       input logic [15:0] w, input logic [15:0] h);
    bus.pix_valid      = pv;
    bus.dp_ready       = dr;
    bus.ctrl_out_ready = cor;
    bus.ctrl_in_valid  = civ;
    bus.ctrl_in_data   = {w, h, 4'h0};
  endtask

  // Called at a falling edge with inputs applied; compares all outputs to the model.
  task automatic settle();
    bit e_pr, e_en;
    logic [35:0] e_data;
    #1;
    e_pr   = (m_mode == MAct) && bus.dp_ready;
    e_en   = e_pr && bus.pix_valid;
    e_data = {16'(m_w / 2), 16'(m_h / 2), 4'h0};
    chk("pix_ready", 64'(bus.pix_ready), 64'(e_pr));
    chk("dp_en", 64'(bus.dp_en), 64'(e_en));
    chk("x", 64'(bus.x), 64'(m_k % m_w));
    chk("y", 64'(bus.y), 64'(m_k / m_w));
    chk("sof", 64'(bus.sof), 64'(e_en && m_k == 0));
    chk("eol", 64'(bus.eol), 64'(e_en && (m_k % m_w) == m_w - 1));
    chk("eof", 64'(bus.eof), 64'(e_en && m_k == m_w * m_h - 1));
    chk("ctrl_in_ready", 64'(bus.ctrl_in_ready), 64'(!m_pend));
    chk("ctrl_out_valid", 64'(bus.ctrl_out_valid), 64'(m_mode == MCfg));
    chk("ctrl_out_data", 64'(bus.ctrl_out_data), 64'(e_data));
    chk("cfg_err", 64'(bus.cfg_err), 64'(m_err));
  endtask

  task automatic advance();
    bit acc, en;
    int nw, nh, ow, oh;
    en  = (m_mode == MAct) && bus.dp_ready && bus.pix_valid;
    acc = bus.ctrl_in_valid && !m_pend;
    nw  = int'(bus.ctrl_in_data[35:20]);
    nh  = int'(bus.ctrl_in_data[19:4]);
    ow  = m_w;
    oh  = m_h;
    if (bus.dp_en) dut_beats++;
    if (bus.eof) begin
      chk("frame_beats", 64'(dut_beats), 64'(m_w * m_h));
      dut_beats = 0;
    end
    case (m_mode)
      MCfg: if (bus.ctrl_out_ready) m_mode = MAct;
      MAct: if (en) begin
        m_k++;
        if (m_k == m_w * m_h) begin
          m_k = 0;
          m_mode = MGap;
        end
      end
      default: if (m_pend) begin
        m_w = m_pw; m_h = m_ph; m_pend = 0; m_mode = MCfg;
      end else begin
        m_mode = MAct;
      end
    endcase
    m_err = 0;
    if (acc) begin
      if (nw == 0 || nh == 0 || nw % 2 != 0 || nh % 2 != 0) m_err = 1;
      else if (nw != ow || nh != oh) begin
        m_pend = 1; m_pw = nw; m_ph = nh;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bit done;
    int beat;

    //               pv dr cor pr en x  y  sof eol eof cov
    tbl[0]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[1]  = '{1, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 1, 1, 2, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 0, 1, 1, 3, 0, 0, 1, 0, 0};
    tbl[5]  = '{1, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0};
    tbl[6]  = '{1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    tbl[7]  = '{1, 1, 0, 1, 1, 2, 1, 0, 0, 0, 0};
    tbl[8]  = '{1, 1, 0, 1, 1, 3, 1, 0, 1, 1, 0};
    tbl[9]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0};

    // Reset values, with upstream/downstream asserting everything.
    drive(1, 1, 1, 0, 16'd0, 16'd0);
    big.pix_valid = 0; big.dp_ready = 1; big.ctrl_out_ready = 1;
    big.ctrl_in_valid = 0; big.ctrl_in_data = '0;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_pix_ready", 64'(bus.pix_ready), 64'd0);
    chk("rst_dp_en", 64'(bus.dp_en), 64'd0);
    chk("rst_sof", 64'(bus.sof), 64'd0);
    chk("rst_eol", 64'(bus.eol), 64'd0);
    chk("rst_eof", 64'(bus.eof), 64'd0);
    chk("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
    chk("rst_ctrl_in_ready", 64'(bus.ctrl_in_ready), 64'd1);
    chk("rst_ctrl_out_valid", 64'(bus.ctrl_out_valid), 64'd1);
    chk("rst_x", 64'(bus.x), 64'd0);
    chk("rst_y", 64'(bus.y), 64'd0);
    chk("rst_ctrl_out_data", 64'(bus.ctrl_out_data), 64'h0_0002_0001_0);
    chk("big_rst_data", 64'(big.ctrl_out_data), 64'h0_03C0_021C_0);
    chk("big_rst_valid", 64'(big.ctrl_out_valid), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Vector table: default 4x2 frame, gap, restart, stall cases.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].pv, tbl[i].dr, tbl[i].cor, 0, 16'd0, 16'd0);
      settle();
      chk($sformatf("tbl%0d_pix_ready", i), 64'(bus.pix_ready), 64'(tbl[i].pr));
      chk($sformatf("tbl%0d_dp_en", i), 64'(bus.dp_en), 64'(tbl[i].en));
      chk($sformatf("tbl%0d_x", i), 64'(bus.x), 64'(tbl[i].x));
      chk($sformatf("tbl%0d_y", i), 64'(bus.y), 64'(tbl[i].y));
      chk($sformatf("tbl%0d_sof", i), 64'(bus.sof), 64'(tbl[i].sof));
      chk($sformatf("tbl%0d_eol", i), 64'(bus.eol), 64'(tbl[i].eol));
      chk($sformatf("tbl%0d_eof", i), 64'(bus.eof), 64'(tbl[i].eof));
      chk($sformatf("tbl%0d_cov", i), 64'(bus.ctrl_out_valid), 64'(tbl[i].cov));
      advance();
    end
    chk("big_one_handshake", 64'(big.ctrl_out_valid), 64'd0);
    chk("big_active", 64'(big.pix_ready), 64'd1);
    chk("big_data_held", 64'(big.ctrl_out_data), 64'h0_03C0_021C_0);

    // Mid-frame {6,4}: frame ends at 4x2, then GAP, CFG, 6x4 frame.
    drive(1, 1, 0, 1, 16'd6, 16'd4);
    settle();
    chk("a_in_ready_before", 64'(bus.ctrl_in_ready), 64'd1);
    advance();
    drive(1, 1, 0, 0, 16'd0, 16'd0);
    settle();
    chk("a_in_ready_held", 64'(bus.ctrl_in_ready), 64'd0);
    advance();
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      settle();
      if (bus.eof) begin
        done = 1;
        chk("a_eof_x", 64'(bus.x), 64'd3);
        chk("a_eof_y", 64'(bus.y), 64'd1);
      end
      advance();
    end
    chk("a_old_eof_seen", 64'(done), 64'd1);
    settle();
    chk("a_gap_pix_ready", 64'(bus.pix_ready), 64'd0);
    advance();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("a_cfg_valid", 64'(bus.ctrl_out_valid), 64'd1);
      chk("a_cfg_data", 64'(bus.ctrl_out_data), 64'h0_0003_0002_0);
      advance();
    end
    drive(1, 1, 1, 0, 16'd0, 16'd0);
    settle();
    advance();
    drive(1, 1, 0, 0, 16'd0, 16'd0);
    done = 0;
    beat = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      settle();
      if (bus.dp_en) begin
        if (bus.eol) chk("a_eol_x", 64'(bus.x), 64'd5);
        if (bus.eof) begin
          done = 1;
          chk("a_eof_beat", 64'(beat), 64'd23);
        end
        beat++;
      end
      advance();
    end
    chk("a_new_eof_seen", 64'(done), 64'd1);

    // Rejected packets in GAP and ACTIVE, then an unchanged geometry packet.
    drive(1, 1, 0, 1, 16'd5, 16'd4);
    settle();
    advance();
    drive(1, 1, 0, 1, 16'd0, 16'd4);
    settle();
    chk("b_err_odd", 64'(bus.cfg_err), 64'd1);
    chk("b_slot_free", 64'(bus.ctrl_in_ready), 64'd1);
    advance();
    drive(1, 1, 0, 1, 16'd6, 16'd4);
    settle();
    chk("b_err_zero", 64'(bus.cfg_err), 64'd1);
    advance();
    drive(1, 1, 0, 0, 16'd0, 16'd0);
    settle();
    chk("b_err_clear", 64'(bus.cfg_err), 64'd0);
    chk("b_same_consumed", 64'(bus.ctrl_in_ready), 64'd1);
    advance();
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      settle();
      done = bus.eof;
      advance();
    end
    chk("b_eof_seen", 64'(done), 64'd1);
    settle();
    advance();
    settle();
    chk("b_no_cfg", 64'(bus.ctrl_out_valid), 64'd0);
    chk("b_dims_kept", 64'(bus.ctrl_out_data), 64'h0_0003_0002_0);
    advance();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 1) != 0, $urandom_range(0, 7) == 0,
            16'(wsel[$urandom_range(0, 5)]), 16'(hsel[$urandom_range(0, 3)]));
      settle();
      advance();
    end

    // Reset at x=2,y=1 with a pending packet; civ held high through reset.
    drive(0, 1, 0, 0, 16'd0, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(0, 1, 1, 0, 16'd0, 16'd0);
    settle();
    advance();
    drive(1, 1, 0, 1, 16'd8, 16'd2);
    settle();
    advance();
    drive(1, 1, 0, 0, 16'd0, 16'd0);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      settle();
      if (bus.x == 16'd2 && bus.y == 16'd1) done = 1;
      else advance();
    end
    chk("d_reached_pos", 64'(done), 64'd1);
    chk("d_pend_set", 64'(bus.ctrl_in_ready), 64'd0);
    rst = 1'b1;
    drive(1, 1, 0, 1, 16'd5, 16'd4);
    #1;
    chk("d_rst_x", 64'(bus.x), 64'd0);
    chk("d_rst_y", 64'(bus.y), 64'd0);
    chk("d_rst_slot", 64'(bus.ctrl_in_ready), 64'd1);
    chk("d_rst_cfg", 64'(bus.ctrl_out_valid), 64'd1);
    chk("d_rst_data", 64'(bus.ctrl_out_data), 64'h0_0002_0001_0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(1, 1, 0, 0, 16'd0, 16'd0);
    settle();
    chk("d_no_capture", 64'(bus.cfg_err), 64'd0);
    advance();
    drive(1, 1, 1, 0, 16'd0, 16'd0);
    for (int i = 0; i < 25; i++) begin
      settle();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
